// File: rtl/mips_debug_pkg.sv
// mips_debug_pkg: shared state encoding, default sizes and phase offsets for the debug dump path.
package mips_debug_pkg;
    typedef enum logic [2:0] {IDLE, SEND, WAIT, FETCH, DONE} state_t;
    localparam int DEF_DATA_WIDTH      = 32;
    localparam int DEF_DATA_WIDTH_UART = 8;
    localparam int DEF_N_REGS          = 32;
    localparam int DEF_N_MEM           = 32;
    localparam int REG_BASE            = 1;
    localparam int MEM_BASE            = 1 + DEF_N_REGS;
    localparam int BYTES_PER_WORD      = DEF_DATA_WIDTH / DEF_DATA_WIDTH_UART;
    function automatic int bytes_per_word(input int dw, input int uw);
        return dw / uw;
    endfunction
endpackage

// File: rtl/dump_word_shifter.sv
// dump_word_shifter: holds the word being sent, shifts out one UART byte at a time and counts bytes.
module dump_word_shifter
    import mips_debug_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int DATA_WIDTH_UART = DEF_DATA_WIDTH_UART
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic                       shift,
    input  logic [DATA_WIDTH-1:0]      word,
    output logic [DATA_WIDTH_UART-1:0] tx_byte,
    output logic                       last_byte
);
    localparam int BPW = bytes_per_word(DATA_WIDTH, DATA_WIDTH_UART);
    localparam int CW  = BPW > 1 ? $clog2(BPW) : 1;
    logic [DATA_WIDTH-1:0] sr;
    logic [CW-1:0]         cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            sr  <= '0;
            cnt <= '0;
        end else if (load) begin
            sr  <= word;
            cnt <= '0;
        end else if (shift) begin
            sr  <= sr >> DATA_WIDTH_UART;
            cnt <= cnt + 1'b1;
        end
    end
    assign tx_byte   = sr[DATA_WIDTH_UART-1:0];
    assign last_byte = cnt == CW'(BPW - 1);
endmodule

// File: rtl/debug_dump_sequencer.sv
// debug_dump_sequencer: streams PC, register file and (with DEBUG_DUMP_MEM_EN) data memory to the debug UART, LSB first.
// Without DEBUG_DUMP_MEM_EN the dump stops after the last register and o_mem_addr is tied to 0.
module debug_dump_sequencer
    import mips_debug_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int DATA_WIDTH_UART = DEF_DATA_WIDTH_UART,
    parameter int N_REGS          = DEF_N_REGS,
    parameter int N_MEM           = DEF_N_MEM
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_start,
    input  logic [DATA_WIDTH-1:0]      i_pc,
    output logic [4:0]                 o_reg_addr,
    input  logic [DATA_WIDTH-1:0]      i_reg_data,
    output logic [4:0]                 o_mem_addr,
    input  logic [DATA_WIDTH-1:0]      i_mem_data,
    output logic                       o_tx_signal,
    output logic [DATA_WIDTH_UART-1:0] o_tx_byte,
    input  logic                       i_tx_done,
    output logic                       o_busy,
    output logic                       o_dump_done
);
    state_t     state;
    logic [6:0] word_idx;
    logic       last_byte;
`ifdef DEBUG_DUMP_MEM_EN
    localparam bit MEM_EN = 1'b1;
`else
    localparam bit MEM_EN = 1'b0;
`endif
    localparam int         N_WORDS  = 1 + N_REGS + (MEM_EN ? N_MEM : 0);
    localparam logic [6:0] REG_LO   = 7'(REG_BASE);
    localparam logic [6:0] MEM_LO   = 7'(REG_BASE + N_REGS);
    localparam logic [6:0] LAST_IDX = 7'(N_WORDS - 1);
    logic last_word;
    logic [DATA_WIDTH-1:0] fetched;
    assign last_word  = word_idx == LAST_IDX;
    assign o_reg_addr = (word_idx >= REG_LO && word_idx < MEM_LO) ? 5'(word_idx - REG_LO) : '0;
`ifdef DEBUG_DUMP_MEM_EN
    assign o_mem_addr = word_idx >= MEM_LO ? 5'(word_idx - MEM_LO) : '0;
    assign fetched    = word_idx >= MEM_LO ? i_mem_data : i_reg_data;
`else
    logic unused_mem;
    assign unused_mem = ^i_mem_data;
    assign o_mem_addr = '0;
    assign fetched    = i_reg_data;
`endif
    dump_word_shifter #(
        .DATA_WIDTH      (DATA_WIDTH),
        .DATA_WIDTH_UART (DATA_WIDTH_UART)
    ) u_shifter (
        .clk       (i_clock),
        .rst       (i_reset),
        .load      ((state == IDLE && i_start) || state == FETCH),
        .shift     (state == WAIT && i_tx_done && !last_byte),
        .word      (state == FETCH ? fetched : i_pc),
        .tx_byte   (o_tx_byte),
        .last_byte (last_byte)
    );
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state       <= IDLE;
            word_idx    <= '0;
            o_tx_signal <= 1'b0;
            o_dump_done <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_tx_signal <= 1'b0;
            o_dump_done <= 1'b0;
            case (state)
                IDLE: if (i_start) begin
                    state       <= SEND;
                    word_idx    <= '0;
                    o_tx_signal <= 1'b1;
                    o_busy      <= 1'b1;
                end
                SEND: state <= WAIT;
                WAIT: if (i_tx_done) begin
                    if (!last_byte) begin
                        state       <= SEND;
                        o_tx_signal <= 1'b1;
                    end else if (last_word) begin
                        state       <= DONE;
                        o_dump_done <= 1'b1;
                    end else begin
                        state    <= FETCH;
                        word_idx <= word_idx + 1'b1;
                    end
                end
                FETCH: begin
                    state       <= SEND;
                    o_tx_signal <= 1'b1;
                end
                DONE: begin
                    state    <= IDLE;
                    word_idx <= '0;
                    o_busy   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
